// File: rtl/fifo_axis_rd.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_axis_rd
//  Description : Read-side adapter from an asynchronous FIFO (registered RAM
//                read, one cycle latency) to a full-rate AXI-Stream master.
//                A two-entry head/skid buffer absorbs the read latency and
//                back-pressure; completed frames are counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_axis_rd #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DATA_WIDTH:0]    fifo_rd_data,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   in_frame,
    output logic [COUNT_WIDTH-1:0] frame_count
);

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_IN_FRAME = 1'b1
    } state_t;

    logic [1:0]             r_occ;
    logic                   r_infl;
    logic                   r_started;
    logic [DATA_WIDTH-1:0]  r_head_data;
    logic                   r_head_last;
    logic [DATA_WIDTH-1:0]  r_skid_data;
    logic                   r_skid_last;
    logic [COUNT_WIDTH-1:0] r_frame_count;
    state_t                 r_state;
    state_t                 w_state_next;

    logic                   w_pop;
    logic [2:0]             w_level;
    logic [1:0]             w_occ_after_pop;
    logic                   w_head_from_fifo;
    logic                   w_head_from_skid;

    // Handshake and buffer-level bookkeeping; the read is only issued when the
    // word it returns next cycle is guaranteed a free slot.
    assign w_pop            = m_axis_tvalid & m_axis_tready;
    assign w_level          = {1'b0, r_occ} + {2'b00, r_infl} - {2'b00, w_pop};
    assign w_occ_after_pop  = r_occ - {1'b0, w_pop};
    assign w_head_from_fifo = r_infl & (w_occ_after_pop == 2'd0);
    assign w_head_from_skid = w_pop & (r_occ == 2'd2);

    assign fifo_rd_en    = r_started & ~fifo_empty & (w_level <= 3'd1);
    assign m_axis_tvalid = (r_occ != 2'd0);
    assign m_axis_tdata  = r_head_data;
    assign m_axis_tlast  = r_head_last;
    assign in_frame      = (r_state == S_IN_FRAME);
    assign frame_count   = r_frame_count;

    // Hold off reads for the first cycle after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
        end
    end

    // Track the read in flight and the number of buffered words.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_infl <= 1'b0;
            r_occ  <= 2'd0;
        end else begin
            r_infl <= fifo_rd_en;
            r_occ  <= w_occ_after_pop + {1'b0, r_infl};
        end
    end

    // Head register: loaded straight from the FIFO when it would otherwise be
    // empty after this cycle's pop, else refilled from skid on a pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head_data <= '0;
            r_head_last <= 1'b0;
        end else if (w_head_from_fifo) begin
            r_head_data <= fifo_rd_data[DATA_WIDTH-1:0];
            r_head_last <= fifo_rd_data[DATA_WIDTH];
        end else if (w_head_from_skid) begin
            r_head_data <= r_skid_data;
            r_head_last <= r_skid_last;
        end
    end

    // Skid register: catches the returning word whenever the head stays busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_skid_data <= '0;
            r_skid_last <= 1'b0;
        end else if (r_infl && !w_head_from_fifo) begin
            r_skid_data <= fifo_rd_data[DATA_WIDTH-1:0];
            r_skid_last <= fifo_rd_data[DATA_WIDTH];
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Frame next-state: any pop of a tlast beat ends the frame, any other pop
    // starts or continues one.
    always_comb begin
        w_state_next = r_state;
        if (w_pop) begin
            if (m_axis_tlast) begin
                w_state_next = S_IDLE;
            end else begin
                w_state_next = S_IN_FRAME;
            end
        end
    end

    // Completed-frame counter, wrapping naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_count <= '0;
        end else if (w_pop && m_axis_tlast) begin
            r_frame_count <= r_frame_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_axis_rd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_axis_rd
//  Description : Self-checking bench for fifo_axis_rd with a behavioural FIFO
//                (one-cycle read latency) and a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_axis_rd;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW:0]   fifo_rd_data;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          in_frame;
    logic [CW-1:0] frame_count;

    fifo_axis_rd #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .in_frame      (in_frame),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO storage and scoreboard.
    logic [DW:0]   mem [0:1023];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic [DW:0]   sb [$];
    int            n_checks = 0;
    int            n_errors = 0;
    logic          bp_mode = 1'b0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input logic l);
        mem[wr_ptr] = {l, d};
        wr_ptr = wr_ptr + 1;
        sb.push_back({l, d});
    endtask

    task automatic push_frame(input int len, input logic [DW-1:0] base);
        for (int i = 0; i < len; i++) begin
            push(base + DW'(i), (i == len - 1));
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // FIFO model: registered read, flushed by the shared reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr       <= wr_ptr;
            fifo_rd_data <= '0;
        end else if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    // Downstream ready: always ready, or the 1,0,0,1 back-pressure pattern.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                m_axis_tready = (ph == 0 || ph == 3);
                ph = (ph + 1) % 4;
            end else begin
                m_axis_tready = 1'b1;
            end
        end
    end

    // Output monitor: scoreboard compare, frame model, AXI hold rules, buffer bound.
    int          outstanding = 0;
    logic [CW-1:0] exp_fc = '0;
    logic        exp_if = 1'b0;
    logic        prev_stall = 1'b0;
    logic [DW:0] prev_word = '0;
    always @(negedge clk) begin
        logic        pop;
        logic [DW:0] w;
        pop = m_axis_tvalid & m_axis_tready;
        if (!reset_n) begin
            outstanding = 0;
            exp_fc      = '0;
            exp_if      = 1'b0;
            prev_stall  = 1'b0;
        end else begin
            chk("in_frame", 32'(in_frame), 32'(exp_if));
            chk("frame_count", 32'(frame_count), 32'(exp_fc));
            chk("rd_when_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
            chk("occ_infl_bound", 32'((outstanding + int'(fifo_rd_en) - int'(pop)) <= 2), 32'd1);
            if (prev_stall) begin
                chk("hold_valid", 32'(m_axis_tvalid), 32'd1);
                chk("hold_data", 32'({m_axis_tlast, m_axis_tdata}), 32'(prev_word));
            end
            if (pop) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 32'({m_axis_tlast, m_axis_tdata}), 32'hFFFF_FFFF);
                end else begin
                    w = sb.pop_front();
                    chk("beat", 32'({m_axis_tlast, m_axis_tdata}), 32'(w));
                    if (w[DW]) begin
                        exp_fc = exp_fc + 1'b1;
                        exp_if = 1'b0;
                    end else begin
                        exp_if = 1'b1;
                    end
                end
            end
            outstanding = outstanding + int'(fifo_rd_en) - int'(pop);
            prev_stall  = m_axis_tvalid & ~m_axis_tready;
            prev_word   = {m_axis_tlast, m_axis_tdata};
        end
    end

    initial begin
        int beats;
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // Single frame at full rate: fall-through latency then 64 back-to-back beats.
        #1;
        push_frame(64, 8'h01);
        @(negedge clk);
        chk("lat_rd_en", 32'(fifo_rd_en), 32'd1);
        chk("lat_cyc0", 32'(m_axis_tvalid), 32'd0);
        @(negedge clk);
        chk("lat_cyc1", 32'(m_axis_tvalid), 32'd0);
        @(negedge clk);
        chk("lat_cyc2", 32'(m_axis_tvalid), 32'd1);
        beats = 1;
        repeat (63) begin
            @(negedge clk);
            beats += int'(m_axis_tvalid & m_axis_tready);
        end
        chk("full_rate_beats", 32'(beats), 32'd64);
        wait_drain(50);
        @(negedge clk);
        #1;
        chk("frame1_count", 32'(frame_count), 32'd1);
        chk("frame1_in_frame", 32'(in_frame), 32'd0);

        // Back-pressure with ready pattern 1,0,0,1.
        bp_mode = 1'b1;
        push_frame(64, 8'h01);
        wait_drain(1000);
        bp_mode = 1'b0;
        @(negedge clk);
        #1;
        chk("bp_count", 32'(frame_count), 32'd2);

        // Underflow mid-frame: FIFO empties after byte 10 for at least 5 cycles.
        push_frame(10, 8'h01);
        mem[wr_ptr - 1][DW] = 1'b0;
        sb[sb.size() - 1][DW] = 1'b0;
        wait_drain(100);
        repeat (5) @(negedge clk);
        #1;
        chk("uf_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("uf_in_frame", 32'(in_frame), 32'd1);
        @(posedge clk);
        #1;
        push_frame(10, 8'h0B);
        wait_drain(100);
        @(negedge clk);
        #1;
        chk("uf_count", 32'(frame_count), 32'd3);
        chk("uf_in_frame_end", 32'(in_frame), 32'd0);

        // Asynchronous reset in the middle of a back-pressured frame.
        bp_mode = 1'b1;
        @(posedge clk);
        #1;
        push_frame(40, 8'h30);
        repeat (8) @(posedge clk);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("arst_tdata", 32'(m_axis_tdata), 32'd0);
        chk("arst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("arst_in_frame", 32'(in_frame), 32'd0);
        chk("arst_count", 32'(frame_count), 32'd0);
        chk("arst_rd_en", 32'(fifo_rd_en), 32'd0);
        bp_mode = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Back-to-back frames of 1, 2 and 60 bytes straight after release.
        push_frame(1, 8'hA0);
        push_frame(2, 8'hB0);
        push_frame(60, 8'h40);
        @(negedge clk);
        chk("rel_rd_en_0", 32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        chk("rel_rd_en_1", 32'(fifo_rd_en), 32'd1);
        wait_drain(200);
        @(negedge clk);
        #1;
        chk("b2b_count", 32'(frame_count), 32'd3);

        // Counter wrap: 17 one-byte frames on a 4-bit counter.
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push_frame(1, DW'(8'hC0 + i));
        end
        wait_drain(200);
        @(negedge clk);
        #1;
        chk("wrap_count", 32'(frame_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
